// File: rtl/led_band_sequencer_pkg.sv
// Shared types and size helpers for the LED band sequencer and its SCLK generator.
package led_band_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2
  } state_t;

  localparam logic [1:0] COLOR_RED   = 2'd2;
  localparam logic [1:0] COLOR_GREEN = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd0;

  function automatic int group_bits(input int bit_per_color, input int nb_0_lsb);
    return 3 * (bit_per_color + nb_0_lsb);
  endfunction

  function automatic int frame_bits(input int nb_led_column, input int bit_per_color,
                                    input int nb_0_lsb);
    return nb_led_column * group_bits(bit_per_color, nb_0_lsb);
  endfunction

endpackage

// File: rtl/led_band_sclk_gen.sv
// SCLK generator: SCLK_DIV-cycle half periods, low phase first, with strobes
// flagging the clk edge on which SCLK will rise or fall.
module led_band_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int PW = $clog2(SCLK_DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_DIV - 1);

  logic [PW-1:0] r_phase;
  logic          r_sclk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_phase == PHASE_LAST);

  // Disabling parks SCLK low with a fresh phase so every frame starts on a clean low half.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_phase <= '0;
      r_sclk  <= 1'b0;
    end else if (w_wrap) begin
      r_phase <= '0;
      r_sclk  <= ~r_sclk;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_wrap && !r_sclk;
  assign o_fall = w_wrap && r_sclk;

endmodule

// File: rtl/led_band_sequencer.sv
// Serial-shift timing for one LED band chain: SCLK, LAT and the row/color/bit read
// coordinates of one grayscale frame per accepted angle tick.
module led_band_sequencer
  import led_band_sequencer_pkg::*;
#(
  parameter int NB_LED_COLUMN = 32,
  parameter int BIT_PER_COLOR = 8,
  parameter int NB_0_LSB      = 1,
  parameter int NB_ANGLES     = 128,
  parameter int SCLK_DIV      = 2,
  parameter int WRTGS_LEN     = 1,
  parameter int LATGS_LEN     = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        run,
  input  logic                                        angle_tick,
  input  logic [$clog2(NB_ANGLES)-1:0]                angle_in,
  output logic                                        SCLK,
  output logic                                        LAT,
  output logic [$clog2(NB_ANGLES)-1:0]                angle,
  output logic [$clog2(NB_LED_COLUMN)-1:0]            row,
  output logic [1:0]                                  color,
  output logic [$clog2(BIT_PER_COLOR+NB_0_LSB)-1:0]   bit_sel,
  output logic                                        busy,
  output logic                                        overrun
);

  localparam int AW  = $clog2(NB_ANGLES);
  localparam int RW  = $clog2(NB_LED_COLUMN);
  localparam int BPB = BIT_PER_COLOR + NB_0_LSB;
  localparam int BW  = $clog2(BPB);
  localparam logic [RW-1:0] ROW_FIRST = RW'(NB_LED_COLUMN - 1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(BPB - 1);

  state_t          r_state;
  logic [AW-1:0]   r_angle;
  logic [RW-1:0]   r_row;
  logic [1:0]      r_color;
  logic [BW-1:0]   r_bitSel;
  logic            r_lat;
  logic            r_busy;
  logic            r_overrun;

  logic            w_sclk;
  logic            w_rise;
  logic            w_fall;
  logic            w_lastBit;
  logic [RW-1:0]   w_nextRow;
  logic [1:0]      w_nextColor;
  logic [BW-1:0]   w_nextBit;

  // Position counted down to the end of the group picks the latch window; the last row uses LATGS.
  function automatic logic latFor(input logic [RW-1:0] r, input logic [1:0] c,
                                  input logic [BW-1:0] b);
    int pos;
    pos = int'(c) * BPB + int'(b);
    if (r == '0) return pos < LATGS_LEN;
    return pos < WRTGS_LEN;
  endfunction

  led_band_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state != ST_IDLE),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_nextRow   = r_row;
    w_nextColor = r_color;
    w_nextBit   = r_bitSel - BW'(1);
    if (r_bitSel == '0) begin
      w_nextBit = BIT_FIRST;
      if (r_color == COLOR_BLUE) begin
        w_nextColor = COLOR_RED;
        w_nextRow   = r_row - RW'(1);
      end else begin
        w_nextColor = r_color - 2'd1;
      end
    end
  end

  assign w_lastBit = (r_row == '0) && (r_color == COLOR_BLUE) && (r_bitSel == '0);

  // Coordinates and LAT only move on SCLK falls so SOUT settles before the next rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_angle   <= '0;
      r_row     <= '0;
      r_color   <= '0;
      r_bitSel  <= '0;
      r_lat     <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= angle_tick && r_busy;
      case (r_state)
        ST_IDLE: begin
          if (angle_tick && run) begin
            r_state  <= ST_SHIFT_LO;
            r_angle  <= angle_in;
            r_row    <= ROW_FIRST;
            r_color  <= COLOR_RED;
            r_bitSel <= BIT_FIRST;
            r_lat    <= latFor(ROW_FIRST, COLOR_RED, BIT_FIRST);
            r_busy   <= 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          if (w_rise) r_state <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          if (w_fall) begin
            if (w_lastBit) begin
              r_state <= ST_IDLE;
              r_lat   <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_state  <= ST_SHIFT_LO;
              r_row    <= w_nextRow;
              r_color  <= w_nextColor;
              r_bitSel <= w_nextBit;
              r_lat    <= latFor(w_nextRow, w_nextColor, w_nextBit);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SCLK    = w_sclk;
  assign LAT     = r_lat;
  assign angle   = r_angle;
  assign row     = r_row;
  assign color   = r_color;
  assign bit_sel = r_bitSel;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_led_band_sequencer.sv
// Scoreboard bench for led_band_sequencer: a frame-order model queues expected per-rise
// coordinates, frame lengths and overrun pulses; monitors pop and compare on DUT events.
module tb_led_band_sequencer;

  localparam int NB_LED_COLUMN = 32;
  localparam int BIT_PER_COLOR = 8;
  localparam int NB_0_LSB      = 1;
  localparam int NB_ANGLES     = 128;
  localparam int WRTGS_LEN     = 1;
  localparam int LATGS_LEN     = 3;
  localparam int SLOT_BITS     = BIT_PER_COLOR + NB_0_LSB;
  localparam int GROUP_BITS    = 3 * SLOT_BITS;
  localparam int FRAME_BITS    = NB_LED_COLUMN * GROUP_BITS;
  localparam int FRAME_CYC     = FRAME_BITS * 2 * 2;
  localparam int FRAME_CYC3    = FRAME_BITS * 2 * 3;

  typedef struct {
    logic [6:0] angle;
    int         row;
    int         color;
    int         bitSel;
    logic       lat;
  } bitExp_t;

  typedef struct {
    int startCyc;
    int len;
    int rises;
    int latPulses;
  } frameExp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, angle_tick;
  logic [6:0] angle_in;
  logic       SCLK, LAT, busy, overrun;
  logic [6:0] angle;
  logic [4:0] row;
  logic [1:0] color;
  logic [3:0] bit_sel;

  logic       run3, tick3;
  logic [6:0] angle3In;
  logic       sclk3, lat3, busy3, overrun3;
  logic [6:0] angle3;
  logic [4:0] row3;
  logic [1:0] color3;
  logic [3:0] bit3;

  led_band_sequencer u_dut (
    .clk(clk), .rst(rst), .run(run), .angle_tick(angle_tick), .angle_in(angle_in),
    .SCLK(SCLK), .LAT(LAT), .angle(angle), .row(row), .color(color),
    .bit_sel(bit_sel), .busy(busy), .overrun(overrun)
  );

  led_band_sequencer #(.SCLK_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .run(run3), .angle_tick(tick3), .angle_in(angle3In),
    .SCLK(sclk3), .LAT(lat3), .angle(angle3), .row(row3), .color(color3),
    .bit_sel(bit3), .busy(busy3), .overrun(overrun3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bitExp_t   bitQ[$];
  bitExp_t   bitQ3[$];
  frameExp_t frameQ[$];
  int        ovQ[$];
  int busyEnd = 0, busyEnd3 = 0, exp3Start = -1;
  int expFramesDone = 0, framesDone = 0, frames3Done = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic bitExp_t modelBit(input int n, input logic [6:0] a);
    bitExp_t e;
    int w, remaining;
    w         = n % GROUP_BITS;
    remaining = GROUP_BITS - 1 - w;
    e.angle   = a;
    e.row     = NB_LED_COLUMN - 1 - n / GROUP_BITS;
    e.color   = 2 - w / SLOT_BITS;
    e.bitSel  = SLOT_BITS - 1 - w % SLOT_BITS;
    e.lat     = (e.row == 0) ? (remaining < LATGS_LEN) : (remaining < WRTGS_LEN);
    return e;
  endfunction

  function automatic int packCoords(input int a, input int r, input int c, input int b,
                                    input int l);
    return (a << 12) | (r << 7) | (c << 5) | (b << 1) | l;
  endfunction

  function automatic logic [6:0] randAngle();
    return 7'($urandom_range(0, NB_ANGLES - 1));
  endfunction

  task automatic startFrame(input int e, input logic [6:0] a);
    frameExp_t f;
    bitExp_t   be;
    logic      prevLat;
    prevLat     = 1'b0;
    f.startCyc  = e;
    f.len       = FRAME_CYC;
    f.rises     = FRAME_BITS;
    f.latPulses = 0;
    for (int n = 0; n < FRAME_BITS; n++) begin
      be = modelBit(n, a);
      bitQ.push_back(be);
      if (be.lat && !prevLat) f.latPulses++;
      prevLat = be.lat;
    end
    frameQ.push_back(f);
    busyEnd = e + FRAME_CYC;
    expFramesDone++;
  endtask

  // Drives one cycle of inputs; the model decides accept/overrun for the edge that samples them.
  task automatic applyStimulus(input logic t, input logic r, input logic [6:0] a);
    int e;
    @(posedge clk);
    #1;
    angle_tick = t;
    run        = r;
    angle_in   = a;
    e          = cyc + 1;
    if (t) begin
      if (e <= busyEnd) ovQ.push_back(e);
      else if (r) startFrame(e, a);
    end
  endtask

  task automatic applyStimulus3(input logic t, input logic r, input logic [6:0] a);
    int e;
    @(posedge clk);
    #1;
    tick3    = t;
    run3     = r;
    angle3In = a;
    e        = cyc + 1;
    if (t && r && e > busyEnd3) begin
      exp3Start = e;
      busyEnd3  = e + FRAME_CYC3;
      for (int n = 0; n < FRAME_BITS; n++) bitQ3.push_back(modelBit(n, a));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " SCLK"}, 32'(SCLK), 0);
    checkOutput({tag, " LAT"}, 32'(LAT), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " overrun"}, 32'(overrun), 0);
    checkOutput({tag, " angle"}, 32'(angle), 0);
    checkOutput({tag, " row"}, 32'(row), 0);
    checkOutput({tag, " color"}, 32'(color), 0);
    checkOutput({tag, " bit_sel"}, 32'(bit_sel), 0);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    angle_tick = 1'b0;
    if (cyc + 1 <= busyEnd) expFramesDone--;
    busyEnd = 0;
    @(posedge clk);
    #1;
    checkResetValues("mid-frame reset");
    rst = 1'b0;
  endtask

  // Main monitor: frame framing, per-rise coordinates, LAT pulse count and overrun timing.
  frameExp_t curFrame;
  bitExp_t   eb;
  logic prevBusy = 0, prevSclk = 0, prevLat = 0, inFrame = 0;
  int   busyCyc = 0, rises = 0, latPulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      bitQ.delete();
      frameQ.delete();
      ovQ.delete();
      prevBusy = 0;
      prevSclk = 0;
      prevLat  = 0;
      inFrame  = 0;
    end else begin
      if (busy && !prevBusy) begin
        busyCyc = 0;
        rises = 0;
        latPulses = 0;
        if (frameQ.size() == 0) begin
          checkOutput("unexpected frame start", 1, 0);
          inFrame = 0;
        end else begin
          curFrame = frameQ.pop_front();
          checkOutput("frame start cycle", cyc, curFrame.startCyc);
          inFrame = 1;
        end
      end
      if (busy) busyCyc++;
      if (SCLK && !prevSclk) begin
        rises++;
        if (bitQ.size() == 0) checkOutput("unexpected SCLK rise", 1, 0);
        else begin
          eb = bitQ.pop_front();
          checkOutput($sformatf("rise %0d packed angle/row/color/bit/lat", rises),
                      packCoords(angle, row, color, bit_sel, LAT),
                      packCoords(eb.angle, eb.row, eb.color, eb.bitSel, eb.lat));
        end
      end
      if (LAT && !prevLat) latPulses++;
      if (!busy && prevBusy && inFrame) begin
        checkOutput("busy length", busyCyc, curFrame.len);
        checkOutput("SCLK rise count", rises, curFrame.rises);
        checkOutput("LAT pulse count", latPulses, curFrame.latPulses);
        framesDone++;
        inFrame = 0;
      end
      if (overrun) begin
        if (ovQ.size() == 0) checkOutput("unexpected overrun", 1, 0);
        else checkOutput("overrun cycle", cyc, ovQ.pop_front());
      end
      prevBusy = busy;
      prevSclk = SCLK;
      prevLat  = LAT;
    end
  end

  // SCLK_DIV=3 monitor: framing plus setup time of the coordinates ahead of each rise.
  bitExp_t eb3;
  logic prevBusy3 = 0, prevSclk3 = 0;
  int   prevCoord3 = 0, stable3 = 0, busyCyc3 = 0, rises3 = 0;

  always @(negedge clk) begin
    if (rst) begin
      bitQ3.delete();
      prevBusy3  = 0;
      prevSclk3  = 0;
      prevCoord3 = 0;
      stable3    = 0;
    end else begin
      if (packCoords(0, row3, color3, bit3, 0) != prevCoord3) stable3 = 1;
      else stable3++;
      prevCoord3 = packCoords(0, row3, color3, bit3, 0);
      if (busy3 && !prevBusy3) begin
        checkOutput("div3 frame start cycle", cyc, exp3Start);
        busyCyc3 = 0;
        rises3 = 0;
      end
      if (busy3) busyCyc3++;
      if (sclk3 && !prevSclk3) begin
        rises3++;
        checks++;
        if (stable3 - 1 < 3) begin
          errors++;
          $display("[TB] FAIL div3 setup before rise %0d: got %0d cycles, need at least 3",
                   rises3, stable3 - 1);
        end
        if (bitQ3.size() == 0) checkOutput("div3 unexpected SCLK rise", 1, 0);
        else begin
          eb3 = bitQ3.pop_front();
          checkOutput($sformatf("div3 rise %0d packed coords", rises3),
                      packCoords(angle3, row3, color3, bit3, lat3),
                      packCoords(eb3.angle, eb3.row, eb3.color, eb3.bitSel, eb3.lat));
        end
      end
      if (!busy3 && prevBusy3) begin
        checkOutput("div3 busy length", busyCyc3, FRAME_CYC3);
        checkOutput("div3 SCLK rise count", rises3, FRAME_BITS);
        frames3Done++;
      end
      if (overrun3) checkOutput("div3 unexpected overrun", 1, 0);
      prevBusy3 = busy3;
      prevSclk3 = sclk3;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int dropAt;
    int i;
    rst = 1'b1; run = 1'b0; angle_tick = 1'b0; angle_in = '0;
    run3 = 1'b0; tick3 = 1'b0; angle3In = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("power-on reset");
    rst = 1'b0;

    // Frame at angle 5 with a dropped tick mid-frame and one on the last busy cycle.
    applyStimulus(1, 1, 7'd5);
    repeat (99) applyStimulus(0, 1, randAngle());
    applyStimulus(1, 1, 7'd9);
    while (cyc + 2 < busyEnd) applyStimulus(0, 1, randAngle());
    applyStimulus(1, 1, randAngle());
    applyStimulus(1, 1, randAngle());

    // Back-to-back frame: random dropped ticks and run released part way through.
    dropAt = $urandom_range(100, 3000);
    i = 0;
    while (cyc + 2 <= busyEnd) begin
      i++;
      applyStimulus($urandom_range(0, 699) == 0, i < dropAt, randAngle());
    end

    // Idle tick with run low must neither start a frame nor flag overrun.
    repeat (5) applyStimulus(0, 0, randAngle());
    applyStimulus(1, 0, randAngle());
    repeat (20) applyStimulus(0, 0, randAngle());

    // Reset in the 1000th busy cycle, then a complete frame afterwards.
    applyStimulus(1, 1, randAngle());
    repeat (999) applyStimulus(0, 1, randAngle());
    resetDut();
    applyStimulus(1, 1, randAngle());
    while (cyc + 2 <= busyEnd) applyStimulus(0, 1, randAngle());

    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 30)) applyStimulus(0, $urandom_range(0, 1) == 1, randAngle());
      applyStimulus(1, 1, randAngle());
      while (cyc + 2 <= busyEnd)
        applyStimulus($urandom_range(0, 999) == 0, 1, randAngle());
    end
    repeat (10) applyStimulus(0, 1, randAngle());

    checkOutput("frames completed", framesDone, expFramesDone);
    checkOutput("coordinate queue drained", bitQ.size(), 0);
    checkOutput("frame queue drained", frameQ.size(), 0);
    checkOutput("overrun queue drained", ovQ.size(), 0);

    // SCLK_DIV=3 instance: one frame with run dropped mid-frame.
    applyStimulus3(1, 1, randAngle());
    dropAt = $urandom_range(50, 4000);
    i = 0;
    while (cyc + 2 <= busyEnd3) begin
      i++;
      applyStimulus3(0, i < dropAt, randAngle());
    end
    repeat (10) applyStimulus3(0, 0, randAngle());
    checkOutput("div3 frames completed", frames3Done, 1);
    checkOutput("div3 coordinate queue drained", bitQ3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
